pc_gen: RTL and testbench



---
 rtl/pc_pkg.sv | 9 +
 rtl/pc_gen_if.sv | 25 ++
 rtl/pc_gen_jump_target.sv | 8 +
 rtl/pc_gen.sv | 58 +++++
 tb/tb_pc_gen.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared PC-generator constants, source select enum and branch-offset helper
package pc_pkg;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    typedef enum logic [2:0] {SEQ, BRANCH, JUMP, JR, PEND, EXC} pc_src_e;
    function automatic logic [63:0] sext_shift(input logic [15:0] imm);
        return {{46{imm[15]}}, imm, 2'b00};
    endfunction
endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-redirect request bus and PC outputs between ID/IF control and pc_gen
interface pc_gen_if #(parameter int ADDR_W = 32, parameter int IDX_W = 26);
    logic              if_stall;
    logic [ADDR_W-1:0] id_pc_plus4;
    logic              jump;
    logic [IDX_W-1:0]  jidx;
    logic              branch_taken;
    logic [15:0]       imm16;
    logic              jr;
    logic [ADDR_W-1:0] jr_target;
    logic              exc_valid;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              flush_if;
    logic              redirect_pending;
    logic              misalign;
    modport master (
        output if_stall, id_pc_plus4, jump, jidx, branch_taken, imm16, jr, jr_target, exc_valid,
        input  pc, pc_plus4, flush_if, redirect_pending, misalign
    );
    modport slave (
        input  if_stall, id_pc_plus4, jump, jidx, branch_taken, imm16, jr, jr_target, exc_valid,
        output pc, pc_plus4, flush_if, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_gen_jump_target.sv
// jump_target: J-type target, upper bits of PC+4 concatenated with the word index
module jump_target #(parameter int ADDR_W = 32, parameter int IDX_W = 26) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [IDX_W-1:0]  jidx,
    output logic [ADDR_W-1:0] target
);
    assign target = {pc_plus4[ADDR_W-1:IDX_W+2], jidx, 2'b00};
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with redirect targets, stall-time request buffer and IF flush
module pc_gen import pc_pkg::*; #(
    parameter int              ADDR_W     = 32,
    parameter int              IDX_W      = 26,
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter bit              DELAY_SLOT = 1'b1
) (
    input logic     clk,
    input logic     rst,
    pc_gen_if.slave bus
);
    logic [ADDR_W-1:0] pc_q, pend_target, jump_tgt, branch_tgt, live_tgt, next_pc;
    logic              pend_valid, pend_exc, misalign_q, flush;
    pc_src_e           live_src, src;
    jump_target #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_jt (
        .pc_plus4 (bus.id_pc_plus4),
        .jidx     (bus.jidx),
        .target   (jump_tgt)
    );
    assign branch_tgt = bus.id_pc_plus4 + ADDR_W'(sext_shift(bus.imm16));
    always_comb begin
        live_src = bus.exc_valid ? EXC : bus.jr ? JR : bus.jump ? JUMP : bus.branch_taken ? BRANCH : SEQ;
        live_tgt = live_src == EXC ? EXC_VECTOR : live_src == JR ? bus.jr_target :
                   live_src == JUMP ? jump_tgt : branch_tgt;
        src      = live_src != SEQ ? live_src : pend_valid ? PEND : SEQ;
        next_pc  = src == SEQ ? pc_q + ADDR_W'(4) : src == PEND ? pend_target : live_tgt;
        // with delay slots only exceptions kill the fetched instruction
        flush    = !bus.if_stall && (DELAY_SLOT ? (src == EXC || (src == PEND && pend_exc)) : src != SEQ);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_exc    <= 1'b0;
            pend_target <= '0;
            misalign_q  <= 1'b0;
        end else if (bus.if_stall) begin
            misalign_q <= 1'b0;
            // a pending exception is never displaced by a later redirect
            if (live_src == EXC || (live_src != SEQ && !pend_exc)) begin
                pend_valid  <= 1'b1;
                pend_exc    <= live_src == EXC;
                pend_target <= live_tgt;
            end
        end else begin
            pc_q       <= next_pc;
            pend_valid <= 1'b0;
            pend_exc   <= 1'b0;
            misalign_q <= src != SEQ && next_pc[1:0] != 2'b00;
        end
    end
    assign bus.pc               = pc_q;
    assign bus.pc_plus4         = pc_q + ADDR_W'(4);
    assign bus.flush_if         = flush;
    assign bus.redirect_pending = pend_valid;
    assign bus.misalign         = misalign_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors into a scoreboard queue; a monitor checks both DELAY_SLOT variants
module tb_pc_gen;
    logic        clk = 1'b0, rst = 1'b1;
    logic        if_stall, jump, branch_taken, jr, exc_valid;
    logic [25:0] jidx;
    logic [15:0] imm16;
    logic [31:0] id_pc_plus4, jr_target;
    int          checks = 0, errors = 0;
    bit          busy = 1'b0;

    pc_gen_if bus1 ();
    pc_gen_if bus0 ();
    assign {bus1.if_stall, bus0.if_stall}         = {2{if_stall}};
    assign {bus1.id_pc_plus4, bus0.id_pc_plus4}   = {2{id_pc_plus4}};
    assign {bus1.jump, bus0.jump}                 = {2{jump}};
    assign {bus1.jidx, bus0.jidx}                 = {2{jidx}};
    assign {bus1.branch_taken, bus0.branch_taken} = {2{branch_taken}};
    assign {bus1.imm16, bus0.imm16}               = {2{imm16}};
    assign {bus1.jr, bus0.jr}                     = {2{jr}};
    assign {bus1.jr_target, bus0.jr_target}       = {2{jr_target}};
    assign {bus1.exc_valid, bus0.exc_valid}       = {2{exc_valid}};

    pc_gen #(.DELAY_SLOT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pc_gen #(.DELAY_SLOT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, jmp;
        logic [25:0] idx;
        logic        br;
        logic [15:0] imm;
        logic        jrr;
        logic [31:0] jrt;
        logic        exc;
        logic [31:0] idpp4, e_pc;
        logic        e_f1, e_f0, e_pend, e_mis;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        f1, f0, pend, mis;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s vec%0d: got %h expected %h", name, id, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            wait (exp_q.size() > 0);
            busy = 1'b1;
            e = exp_q.pop_front();
            chk("flush_if_ds1", e.id, 32'(bus1.flush_if), 32'(e.f1));
            chk("flush_if_ds0", e.id, 32'(bus0.flush_if), 32'(e.f0));
            @(posedge clk);
            #1;
            chk("pc_ds1", e.id, bus1.pc, e.pc);
            chk("pc_ds0", e.id, bus0.pc, e.pc);
            chk("pc_plus4", e.id, bus1.pc_plus4, e.pc + 32'd4);
            chk("redirect_pending", e.id, 32'(bus1.redirect_pending), 32'(e.pend));
            chk("misalign", e.id, 32'(bus1.misalign), 32'(e.mis));
            busy = 1'b0;
        end
    end

    initial begin : stim
        //               stall jmp idx         br   imm       jr   jrt           exc  idpp4         e_pc          f1 f0 pend mis
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    0, 32'h0,        0, 32'h0,        32'h0000_3004, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    0, 32'h0,        0, 32'h0,        32'h0000_3008, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 26'h0000100, 0, 16'h0,    0, 32'h0,        0, 32'h9000_0010, 32'h9000_0400, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 26'h0,       1, 16'hFFFE, 0, 32'h0,        0, 32'h0000_3010, 32'h0000_3008, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 26'h0,       1, 16'h0040, 0, 32'h0,        0, 32'h0000_3000, 32'h0000_3008, 0, 0, 1, 0});
        vecs.push_back('{1, 0, 26'h0,       0, 16'h0,    1, 32'h0000_3200, 0, 32'h0,        32'h0000_3008, 0, 0, 1, 0});
        vecs.push_back('{1, 0, 26'h0,       0, 16'h0,    0, 32'h0,        0, 32'h0,        32'h0000_3008, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    0, 32'h0,        0, 32'h0,        32'h0000_3200, 0, 1, 0, 0});
        vecs.push_back('{1, 0, 26'h0,       0, 16'h0,    0, 32'h0,        1, 32'h0,        32'h0000_3200, 0, 0, 1, 0});
        vecs.push_back('{1, 1, 26'h0000100, 0, 16'h0,    0, 32'h0,        0, 32'h9000_0010, 32'h0000_3200, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    0, 32'h0,        0, 32'h0,        32'h0000_4180, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    1, 32'h0000_3002, 0, 32'h0,        32'h0000_3002, 0, 1, 0, 1});
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    0, 32'h0,        0, 32'h0,        32'h0000_3006, 0, 0, 0, 0});
        vecs.push_back('{1, 1, 26'h0000100, 0, 16'h0,    0, 32'h0,        0, 32'h9000_0010, 32'h0000_3006, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 26'h0,       1, 16'h0004, 0, 32'h0,        0, 32'h0000_3010, 32'h0000_3020, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    0, 32'h0,        0, 32'h0,        32'h0000_3024, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    1, 32'h0000_5000, 1, 32'h0,        32'h0000_4180, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    1, 32'hFFFF_FFFC, 0, 32'h0,        32'hFFFF_FFFC, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 26'h0,       0, 16'h0,    0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, 0, 0, 0});
        vecs.push_back('{1, 0, 26'h0,       1, 16'h0040, 0, 32'h0,        0, 32'h0000_3000, 32'h0000_0000, 0, 0, 1, 0});
        {if_stall, jump, branch_taken, jr, exc_valid} = '0;
        {jidx, imm16, id_pc_plus4, jr_target} = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_pc", -1, bus1.pc, 32'h0000_3000);
        chk("reset_pending", -1, 32'(bus1.redirect_pending), 32'h0);
        chk("reset_misalign", -1, 32'(bus1.misalign), 32'h0);
        chk("reset_flush_ds0", -1, 32'(bus0.flush_if), 32'h0);
        foreach (vecs[i]) begin
            if_stall = vecs[i].stall; jump = vecs[i].jmp; jidx = vecs[i].idx;
            branch_taken = vecs[i].br; imm16 = vecs[i].imm; jr = vecs[i].jrr;
            jr_target = vecs[i].jrt; exc_valid = vecs[i].exc; id_pc_plus4 = vecs[i].idpp4;
            #1;
            exp_q.push_back('{i, vecs[i].e_pc, vecs[i].e_f1, vecs[i].e_f0, vecs[i].e_pend, vecs[i].e_mis});
            @(negedge clk);
            #1;
        end
        for (int n = 0; n < 50 && (exp_q.size() != 0 || busy); n++) @(posedge clk);
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
        end
        @(negedge clk);
        {jump, branch_taken, jr, exc_valid} = '0;
        if_stall = 1'b1;
        #2;
        chk("pending_before_reset", -2, 32'(bus1.redirect_pending), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_reset_pc_ds1", -2, bus1.pc, 32'h0000_3000);
        chk("async_reset_pc_ds0", -2, bus0.pc, 32'h0000_3000);
        chk("async_reset_pending", -2, 32'(bus1.redirect_pending), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        if_stall = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_pc", -3, bus1.pc, 32'h0000_3004);
        chk("post_reset_pending", -3, 32'(bus0.redirect_pending), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
